mem_serializer: RTL and testbench
=================================

MEM_SERIALIZER -- requirements
Module: mem_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 16, meaning width of each word.
REQ-002 SHALL have parameter NUM_WORDS, default 16, meaning words per vector (legal range >= 2).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  meaning in_data/in_desc are valid.
REQ-006 SHALL have port in_ready  output  1  meaning the block can capture a vector this cycle.
REQ-007 SHALL have port in_data  input  NUM_WORDS x WORD_W  meaning the packed vector of words.
REQ-008 SHALL have port in_desc  input  1  meaning emit order: 1 = index NUM_WORDS-1 down to 0; 0 = index 0 up to NUM_WORDS-1.
REQ-009 SHALL have port out_valid  output  1  meaning out_data holds a valid word.
REQ-010 SHALL have port out_ready  input  1  meaning the consumer accepts the word this cycle.
REQ-011 SHALL have port out_data  output  WORD_W  meaning the current word.
REQ-012 SHALL have port out_idx  output  $clog2(NUM_WORDS)  meaning the vector index of out_data.
REQ-013 SHALL have port out_last  output  1  meaning the current word is the final word of the vector.
REQ-014 SHALL have port done  output  1  meaning a one-cycle pulse marking that a vector has been fully emitted.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and SEND.
REQ-016 SHALL drive in_ready = 1 in IDLE, and in SEND only in the cycle where out_valid & out_ready & out_last.
REQ-017 SHALL, on in_valid & in_ready, capture in_data into an internal buffer and latch in_desc, then enter SEND.
REQ-018 SHALL load idx on capture: NUM_WORDS-1 when in_desc = 1, otherwise 0.
REQ-019 SHALL present the first word with out_valid = 1 in the cycle after capture (latency 1).
REQ-020 SHALL drive out_data = buffer[idx] and out_idx = idx while in SEND.
REQ-021 SHALL hold out_data, out_idx and out_last stable while out_valid & !out_ready (back-pressure); in_data changes in SEND SHALL have no effect.
REQ-022 SHALL, on out_valid & out_ready with out_last = 0, step idx by -1 (desc) or +1 (asc) in the next cycle.
REQ-023 SHALL assert out_last when idx = 0 (desc) or idx = NUM_WORDS-1 (asc); idx SHALL never wrap.
REQ-024 SHALL, on acceptance of the last word, pulse done for exactly the next cycle, and go to IDLE unless a new vector is captured in the same cycle.
REQ-025 SHALL, when a new vector is captured in the last-word accept cycle, remain in SEND with the new vector's first word in the next cycle; throughput is one vector per NUM_WORDS cycles with no bubble.
REQ-026 SHALL drive out_data, out_idx and out_last to 0 whenever out_valid = 0.
REQ-027 SHALL register done; done SHALL be 0 in every other cycle.

Reset
REQ-028 SHALL, while rst = 1 at a clock edge, set FSM = IDLE, idx = 0, buffer = 0, out_valid = 0, done = 0, and ignore in_valid.
REQ-029 SHALL drive in_ready = 0 during any cycle in which rst = 1.
REQ-030 SHALL abort a vector in progress on reset with no done pulse, and resume in IDLE with in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, with macro MEM_SERIALIZER_PARITY_EN defined, add port out_parity (output, 1 bit) equal to the XOR of all bits of out_data, which is 0 when out_valid = 0.
REQ-032 SHALL, without MEM_SERIALIZER_PARITY_EN, omit port out_parity and all parity logic; every other behaviour is identical.

Verification
REQ-033 Descending case: NUM_WORDS=16, word i = 16'h1000+i, in_desc=1, out_ready=1 -> cycles 1..16 emit 16'h100F..16'h1000, out_last only on 16'h1000, done in cycle 17.
REQ-034 Ascending case: same vector with in_desc=0 -> emits 16'h1000..16'h100F, out_idx 0..15, out_last on idx 15.
REQ-035 Back-pressure: out_ready=0 for 3 cycles on idx 7 -> word 16'h1007 is held for 4 cycles and is emitted once; there are no gaps or duplicates.
REQ-036 Back-to-back: second vector (word i = 16'h2000+i) is valid during the last-word accept -> 16'h2000-series starts next cycle with no bubble, and done pulses once per vector.
REQ-037 Reset mid-vector: rst=1 after 5 words -> out_valid=0 and no done pulse; the next vector restarts from its first word.
REQ-038 Parity (MEM_SERIALIZER_PARITY_EN): word 16'h0007 -> out_parity=1; word 16'h0003 -> out_parity=0.

Source files
------------

// File: rtl/mem_serializer.sv
// mem_serializer
//
// Captures a packed vector of NUM_WORDS words in one handshake and emits it
// one word per accepted cycle, either ascending (index 0 first) or descending
// (index NUM_WORDS-1 first). A new vector can be captured in the same cycle as
// the last word is accepted, so back-to-back vectors stream with no bubble.
//
// Parameters:
//   WORD_W    - width of each word
//   NUM_WORDS - words per vector (>= 2)
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   in_valid   - in_data/in_desc are valid
//   in_ready   - block can capture a vector this cycle
//   in_data    - packed vector, word i at bits [i*WORD_W +: WORD_W]
//   in_desc    - 1 = emit NUM_WORDS-1 down to 0, 0 = emit 0 up to NUM_WORDS-1
//   out_valid  - out_data holds a valid word
//   out_ready  - consumer accepts the word this cycle
//   out_data   - current word (0 when out_valid = 0)
//   out_idx    - vector index of out_data (0 when out_valid = 0)
//   out_last   - current word is the final word of the vector
//   done       - one-cycle pulse after the last word was accepted
//   out_parity - XOR of all out_data bits (only with MEM_SERIALIZER_PARITY_EN)
//
// Optional feature macro: MEM_SERIALIZER_PARITY_EN

module mem_serializer #(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_WORDS*WORD_W-1:0]   in_data,
    input  logic                          in_desc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic [$clog2(NUM_WORDS)-1:0]  out_idx,
    output logic                          out_last,
    output logic                          done
`ifdef MEM_SERIALIZER_PARITY_EN
    ,
    output logic                          out_parity
`endif
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] buffer [NUM_WORDS];
    logic              desc;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic              last_word;
    logic              accept;
    logic              capture;

    // State register. Reset aborts any vector in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output logic. in_ready is gated by rst so nothing is
    // captured during reset. In SEND the block only reopens its input in the
    // cycle the last word is accepted, which is what lets a new vector follow
    // immediately. A capture always wins over the return to IDLE.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_idx    = '0;
        out_last   = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        last_word  = desc ? (idx == '0) : (idx == LAST_IDX);

        case (state)
            IDLE: begin
                in_ready = !rst;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = buffer[idx];
                out_idx   = idx;
                out_last  = last_word;
                accept    = out_ready;
                in_ready  = !rst && out_ready && last_word;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        capture = in_valid && in_ready;

        if (accept && !last_word) begin
            idx_next = desc ? (idx - 1'b1) : (idx + 1'b1);
        end

        if (accept && last_word) begin
            state_next = IDLE;
        end

        if (capture) begin
            state_next = SEND;
            idx_next   = in_desc ? LAST_IDX : '0;
        end
    end

    // Datapath registers: word buffer, emit direction, index and the done
    // pulse. The buffer is only written on capture, so in_data changes while
    // a vector is being sent have no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            desc <= 1'b0;
            done <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            idx  <= idx_next;
            done <= accept && last_word;
            if (capture) begin
                desc <= in_desc;
                for (int i = 0; i < NUM_WORDS; i++) begin
                    buffer[i] <= in_data[i*WORD_W +: WORD_W];
                end
            end
        end
    end

`ifdef MEM_SERIALIZER_PARITY_EN
    // out_data is already forced to 0 when idle, so parity is 0 there too.
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_mem_serializer.sv
// tb_mem_serializer
//
// Self-checking bench for mem_serializer (WORD_W = 16, NUM_WORDS = 16).
// Directed table of per-cycle vectors for the ascending/descending cases,
// hand-written back-pressure, back-to-back, reset and parity sequences, then
// a randomized run compared against a vector-level reference model.

module tb_mem_serializer;

    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 16;
    localparam int IDX_W     = 4;
    localparam int VEC_W     = NUM_WORDS * WORD_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [VEC_W-1:0]  in_data;
    logic              in_desc;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              done;
`ifdef MEM_SERIALIZER_PARITY_EN
    logic              out_parity;
`endif

    int checks = 0;
    int passed = 0;

    mem_serializer #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done)
`ifdef MEM_SERIALIZER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              in_valid;
        logic              in_desc;
        logic              out_ready;
        logic [VEC_W-1:0]  data;
        logic              exp_in_ready;
        logic              exp_valid;
        logic              exp_last;
        logic              exp_done;
        logic [WORD_W-1:0] exp_data;
        logic [IDX_W-1:0]  exp_idx;
    } vec_t;

    vec_t tbl [38];

    // Reference model: one vector in flight, described by how many of its
    // words have been accepted so far.
    logic              m_busy = 1'b0;
    logic              m_desc = 1'b0;
    int                m_k    = 0;
    logic [VEC_W-1:0]  m_vec  = '0;
    logic              m_done = 1'b0;
    logic              m_fire;
    logic [WORD_W-1:0] dut_acc [$];

    function automatic logic [VEC_W-1:0] mkVec(input logic [WORD_W-1:0] base);
        logic [VEC_W-1:0] v;
        for (int i = 0; i < NUM_WORDS; i++) begin
            v[i*WORD_W +: WORD_W] = base + WORD_W'(i);
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic d,
                                 input logic [VEC_W-1:0] data, input logic ordy);
        rst       = r;
        in_valid  = v;
        in_desc   = d;
        in_data   = data;
        out_ready = ordy;
    endtask

    // Compare the DUT against the model for the current cycle, then advance
    // the model across the coming clock edge.
    task automatic modelCheck(input string tag);
        int                pos;
        logic              e_last;
        logic              e_ready;
        logic [WORD_W-1:0] e_data;
        logic [IDX_W-1:0]  e_idx;
        pos     = m_desc ? (NUM_WORDS - 1 - m_k) : m_k;
        e_last  = m_busy && (m_k == NUM_WORDS - 1);
        e_data  = m_busy ? m_vec[pos*WORD_W +: WORD_W] : '0;
        e_idx   = m_busy ? IDX_W'(pos) : '0;
        e_ready = !rst && (!m_busy || (out_ready && e_last));
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(m_busy));
        checkOutput({tag, ".out_data"},  32'(out_data),  32'(e_data));
        checkOutput({tag, ".out_idx"},   32'(out_idx),   32'(e_idx));
        checkOutput({tag, ".out_last"},  32'(out_last),  32'(e_last));
        checkOutput({tag, ".in_ready"},  32'(in_ready),  32'(e_ready));
        checkOutput({tag, ".done"},      32'(done),      32'(m_done));
`ifdef MEM_SERIALIZER_PARITY_EN
        checkOutput({tag, ".out_parity"}, 32'(out_parity), 32'(^e_data));
`endif
        if (!rst && out_valid && out_ready) dut_acc.push_back(out_data);
        m_fire = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
        end else begin
            m_done = m_busy && out_ready && e_last;
            m_fire = in_valid && e_ready;
            if (m_busy && out_ready) begin
                if (e_last) m_busy = 1'b0;
                else        m_k++;
            end
            if (m_fire) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_vec  = in_data;
                m_desc = in_desc;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic d,
                         input logic [VEC_W-1:0] data, input logic ordy, input string tag);
        @(negedge clk);
        applyStimulus(r, v, d, data, ordy);
        #1;
        modelCheck(tag);
    endtask

    initial begin
        logic [VEC_W-1:0] vec_a;
        logic [VEC_W-1:0] vec_b;
        logic [VEC_W-1:0] vec_p;
        logic [VEC_W-1:0] rnd;
        int held, cnt_1007, valid_cnt, done_cnt;
        logic b_taken;

        vec_a = mkVec(16'h1000);
        vec_b = mkVec(16'h2000);
        vec_p = '0;
        vec_p[15:0]  = 16'h0007;
        vec_p[31:16] = 16'h0003;

        // Directed table: reset, descending vector, ascending vector.
        for (int e = 0; e < 38; e++) begin
            tbl[e] = '{rst: 1'b0, in_valid: 1'b0, in_desc: 1'b0, out_ready: 1'b1,
                       data: vec_a, exp_in_ready: 1'b0, exp_valid: 1'b0,
                       exp_last: 1'b0, exp_done: 1'b0, exp_data: '0, exp_idx: '0};
        end
        for (int e = 0; e < 2; e++) begin
            tbl[e].rst      = 1'b1;
            tbl[e].in_valid = 1'b1;
        end
        tbl[2].in_valid = 1'b1;
        tbl[2].in_desc  = 1'b1;
        tbl[2].exp_in_ready = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tbl[2+c].exp_valid    = 1'b1;
            tbl[2+c].exp_data     = 16'h100F - WORD_W'(c - 1);
            tbl[2+c].exp_idx      = IDX_W'(16 - c);
            tbl[2+c].exp_last     = (c == 16);
            tbl[2+c].exp_in_ready = (c == 16);
        end
        tbl[19].in_valid     = 1'b1;
        tbl[19].exp_done     = 1'b1;
        tbl[19].exp_in_ready = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tbl[19+c].exp_valid    = 1'b1;
            tbl[19+c].exp_data     = 16'h1000 + WORD_W'(c - 1);
            tbl[19+c].exp_idx      = IDX_W'(c - 1);
            tbl[19+c].exp_last     = (c == 16);
            tbl[19+c].exp_in_ready = (c == 16);
        end
        tbl[36].exp_done     = 1'b1;
        tbl[36].exp_in_ready = 1'b1;
        tbl[37].exp_in_ready = 1'b1;

        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int e = 0; e < 38; e++) begin
            @(negedge clk);
            applyStimulus(tbl[e].rst, tbl[e].in_valid, tbl[e].in_desc, tbl[e].data, tbl[e].out_ready);
            #1;
            checkOutput($sformatf("tbl%0d.in_ready", e),  32'(in_ready),  32'(tbl[e].exp_in_ready));
            checkOutput($sformatf("tbl%0d.out_valid", e), 32'(out_valid), 32'(tbl[e].exp_valid));
            checkOutput($sformatf("tbl%0d.out_data", e),  32'(out_data),  32'(tbl[e].exp_data));
            checkOutput($sformatf("tbl%0d.out_idx", e),   32'(out_idx),   32'(tbl[e].exp_idx));
            checkOutput($sformatf("tbl%0d.out_last", e),  32'(out_last),  32'(tbl[e].exp_last));
            checkOutput($sformatf("tbl%0d.done", e),      32'(done),      32'(tbl[e].exp_done));
        end

        // Back-pressure: stall three cycles on index 7 of an ascending vector.
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, "bp_rst");
        dut_acc.delete();
        cycle(1'b0, 1'b1, 1'b0, vec_a, 1'b1, "bp_cap");
        held = 0;
        cnt_1007 = 0;
        for (int c = 0; c < 22; c++) begin
            logic rdy;
            rdy = 1'b1;
            if (m_busy && m_k == 7 && held < 3) begin
                rdy = 1'b0;
                held++;
            end
            cycle(1'b0, 1'b0, 1'b0, mkVec(16'hDEAD), rdy, "bp");
            if (out_valid && out_data == 16'h1007) cnt_1007++;
        end
        checkOutput("bp_hold_cycles", 32'(cnt_1007), 32'd4);
        checkOutput("bp_word_count", 32'(dut_acc.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("bp_word%0d", i),
                        (i < dut_acc.size()) ? 32'(dut_acc[i]) : 32'hFFFF_FFFF, 32'h1000 + 32'(i));
        end

        // Back-to-back: descending vector, second vector waits on in_valid.
        cycle(1'b0, 1'b1, 1'b1, vec_a, 1'b1, "b2b_cap");
        b_taken = 1'b0;
        valid_cnt = 0;
        done_cnt = 0;
        for (int c = 1; c <= 36; c++) begin
            cycle(1'b0, !b_taken, 1'b0, vec_b, 1'b1, "b2b");
            if (m_fire) b_taken = 1'b1;
            if (c <= 32 && out_valid) valid_cnt++;
            if (done) done_cnt++;
            if (c == 17) checkOutput("b2b_first_b", 32'(out_data), 32'h2000);
        end
        checkOutput("b2b_valid_cycles", 32'(valid_cnt), 32'd32);
        checkOutput("b2b_done_pulses", 32'(done_cnt), 32'd2);

        // Reset mid-vector after five accepted words.
        cycle(1'b0, 1'b1, 1'b0, vec_a, 1'b1, "rst_cap");
        for (int c = 1; c <= 5; c++) cycle(1'b0, 1'b0, 1'b0, vec_a, 1'b1, "rst_run");
        done_cnt = 0;
        cycle(1'b1, 1'b1, 1'b0, vec_b, 1'b1, "rst_on");
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b0, 1'b0, vec_b, 1'b1, "rst_after");
            if (done) done_cnt++;
            if (c == 0) begin
                checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
                checkOutput("rst_resume_ready", 32'(in_ready), 32'd1);
            end
        end
        checkOutput("rst_no_done", 32'(done_cnt), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, vec_b, 1'b1, "rst_recap");
        cycle(1'b0, 1'b0, 1'b0, vec_b, 1'b1, "rst_first");
        checkOutput("rst_restart_data", 32'(out_data), 32'h2000);
        checkOutput("rst_restart_idx", 32'(out_idx), 32'd0);
        for (int c = 0; c < 16; c++) cycle(1'b0, 1'b0, 1'b0, vec_b, 1'b1, "rst_drain");

        // Parity words 0x0007 then 0x0003, ascending.
        cycle(1'b0, 1'b1, 1'b0, vec_p, 1'b1, "par_cap");
        cycle(1'b0, 1'b0, 1'b0, vec_p, 1'b1, "par_w0");
`ifdef MEM_SERIALIZER_PARITY_EN
        checkOutput("parity_0007", 32'(out_parity), 32'd1);
`endif
        cycle(1'b0, 1'b0, 1'b0, vec_p, 1'b1, "par_w1");
`ifdef MEM_SERIALIZER_PARITY_EN
        checkOutput("parity_0003", 32'(out_parity), 32'd0);
`endif
        for (int c = 0; c < 16; c++) cycle(1'b0, 1'b0, 1'b0, vec_p, 1'b1, "par_drain");

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_WORDS; i++) rnd[i*WORD_W +: WORD_W] = WORD_W'($urandom);
            cycle($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, rnd, $urandom_range(0, 9) < 7, "rnd");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
